nibble_serial_add_sub: RTL
==========================

Name: nibble_serial_add_sub

Overview:
Nibble-serial sequencer that performs WIDTH-bit add/subtract by driving an external 4-bit ripple-carry adder one nibble per clock, LSB nibble first. It sits directly upstream and downstream of that adder. It feeds the adder's A/B/Cin inputs from latched operands, and it captures the adder's Sum/Cout into a result register. A start/done handshake presents it to the lab-level control logic.

Parameters:
NIBBLES, 4, number of 4-bit slices; operand width WIDTH = 4*NIBBLES (minimum 1).

Ports:
clk  in  1  system clock; all state changes on rising edge.
rst_n  in  1  synchronous, active-low reset.
start  in  1  request; sampled on rising edge; accepted only in IDLE or DONE.
sub  in  1  0 = A+B, 1 = A−B; latched on accepted start.
op_a  in  WIDTH  operand A; latched on accepted start.
op_b  in  WIDTH  operand B; latched on accepted start.
busy  out  1  high while in RUN.
done  out  1  one-cycle pulse, high while in DONE.
result  out  WIDTH  sum/difference; holds until the next accepted start.
carry_out  out  1  final nibble Cout (for sub: 1 = no borrow, A ≥ B unsigned).
overflow  out  1  two's-complement overflow of the full-width operation.
adder_a  out  4  A nibble to the external adder.
adder_b  out  4  effective B nibble to the external adder (inverted when sub).
adder_cin  out  1  carry-in to the external adder.
adder_sum  in  4  Sum from the external adder (combinational from adder_a/b/cin).
adder_cout  in  1  Cout from the external adder.

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at an edge):
  - state=IDLE; busy=0, done=0.
  - result=0, carry_out=0, overflow=0.
  - adder_a=0, adder_b=0, adder_cin=0.
  - Nibble index=0; any operation in progress is aborted with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0; adder_* outputs driven 0.
- IDLE, start=1 at an edge:
  - Latch A=op_a.
  - Latch Beff = sub ? ~op_b : op_b.
  - carry register = sub.
  - Index = 0, result cleared to 0, next state RUN.
- RUN, combinational drive:
  - adder_a = A[4*idx+3:4*idx].
  - adder_b = Beff[4*idx+3:4*idx].
  - adder_cin = carry register.
- RUN, at each edge:
  - result[4*idx+3:4*idx] <= adder_sum.
  - carry register <= adder_cout.
  - idx <= idx+1.
- RUN exit: when idx == NIBBLES−1 the edge also performs:
  - carry_out <= adder_cout.
  - overflow <= (A[WIDTH−1] == Beff[WIDTH−1]) && (adder_sum[3] != A[WIDTH−1]).
  - state <= DONE.
- Latency: with start accepted at edge 0, RUN occupies cycles 1..NIBBLES and done is high in cycle NIBBLES+1 (cycle 5 for default).
- DONE: done=1 for exactly one cycle, busy=0.
  - result, carry_out and overflow are valid from this cycle and held stable until the next accepted start.
  - Next state IDLE.
  - start=1 in DONE is accepted exactly as in IDLE: go straight to RUN, operands latched, done still pulses this cycle.
- start during RUN: ignored. Latched operands are unaffected, and op_a/op_b/sub changes are ignored.
- Wrap-around: arithmetic is modulo 2^WIDTH. Carry/borrow appears only on carry_out, never in result.
- carry_out and overflow are cleared when a new start is accepted.
- The adder interface carries no handshake. The block relies on the adder settling within one clock period.

Test Plan:
1. add, op_a=0x1234, op_b=0x4321, start one cycle -> busy high for 4 cycles; done pulses in cycle 5; result=0x5555, carry_out=0, overflow=0; adder_cin=0,0,0,0 on successive RUN cycles.
2. add, 0xFFFF+0x0001 -> result=0x0000, carry_out=1, overflow=0; adder_cin sequence 0,1,1,1. Then 0x7FFF+0x0001 -> result=0x8000, carry_out=0, overflow=1.
3. sub, 0x0005−0x0007 -> result=0xFFFE, carry_out=0 (borrow), overflow=0. Then sub 0x8000−0x0001 -> result=0x7FFF, carry_out=1, overflow=1.
4. Start 0x1111+0x2222 and pulse start with 0xAAAA+0x5555 in RUN cycle 2 -> second start ignored; result=0x3333. Holding start=1 during DONE launches the next op back-to-back, with done at cycle 5 and cycle 10.
5. Start 0x1234+0x4321 and drive rst_n=0 in RUN cycle 2 -> next cycle state IDLE; busy=0, result=0, adder_*=0; no done pulse. A subsequent add of 0x0001+0x0001 gives result=0x0002.
6. Set NIBBLES=1 and add 0xF+0x1 -> done in cycle 2, result=0x0, carry_out=1, overflow=0.

Source files
------------

// File: rtl/nibble_serial_add_sub.sv
// ---------------------------------------------------------------------------
// nibble_serial_add_sub
//
// Performs a WIDTH-bit add or subtract (WIDTH = 4*NIBBLES) by driving an
// external 4-bit ripple-carry adder one nibble per clock, least-significant
// nibble first. Operands are latched when a start is accepted. Each RUN cycle
// one nibble of A, the matching nibble of the effective B (inverted for
// subtract) and the running carry go to the adder. The adder's sum and carry
// are captured on the next rising edge.
//
// Subtraction is A + ~B + 1. The inverted B is latched once, and the initial
// carry is seeded with 1. After the last nibble, carry_out is therefore the
// "no borrow" flag (1 means A >= B unsigned).
//
// Ports
//   clk         in   1      system clock, rising edge
//   rst_n       in   1      synchronous active-low reset
//   start       in   1      request, accepted in IDLE or DONE only
//   sub         in   1      0 = A+B, 1 = A-B (latched on accept)
//   op_a        in   WIDTH  operand A (latched on accept)
//   op_b        in   WIDTH  operand B (latched on accept)
//   busy        out  1      high while in RUN
//   done        out  1      high for the single DONE cycle
//   result      out  WIDTH  sum / difference, held until next accept
//   carry_out   out  1      final nibble carry (sub: 1 = no borrow)
//   overflow    out  1      two's-complement overflow of the full operation
//   adder_a     out  4      A nibble to the external adder
//   adder_b     out  4      effective B nibble to the external adder
//   adder_cin   out  1      carry-in to the external adder
//   adder_sum   in   4      sum from the external adder (combinational)
//   adder_cout  in   1      carry-out from the external adder
// ---------------------------------------------------------------------------
module nibble_serial_add_sub #(
  parameter int NIBBLES = 4,
  parameter int WIDTH   = 4 * NIBBLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic [3:0]       adder_a,
  output logic [3:0]       adder_b,
  output logic             adder_cin,
  input  logic [3:0]       adder_sum,
  input  logic             adder_cout
);

  // Nibble index width. A single-nibble build still needs a one-bit register.
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // Operands and result are held as nibble arrays, so the active slice is a
  // plain index by the nibble counter.
  logic [NIBBLES-1:0][3:0] a_q;
  logic [NIBBLES-1:0][3:0] beff_q;
  logic [NIBBLES-1:0][3:0] result_q;
  logic                    carry_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    carry_out_q;
  logic                    overflow_q;

  logic accept;
  logic last_nibble;

  // A request is taken in IDLE and also in DONE, which allows back-to-back
  // operations without an idle gap. A request during RUN is dropped.
  assign accept      = start && (state_q != S_RUN);
  assign last_nibble = (idx_q == LAST_IDX);

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  // NOTE: clocked state is written only with non-blocking assignments. All
  // registers then update together at the edge, and the result does not
  // depend on the order in which the always blocks are evaluated.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  // NOTE: every signal assigned in a combinational block gets a default
  // first. If any path left a signal unassigned, synthesis would infer a
  // latch to hold its old value.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_nibble) state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q         <= '0;
      beff_q      <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (accept) begin
      a_q         <= op_a;
      beff_q      <= sub ? ~op_b : op_b;
      carry_q     <= sub;               // +1 completes the two's complement
      idx_q       <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (state_q == S_RUN) begin
      result_q[idx_q] <= adder_sum;
      carry_q         <= adder_cout;
      if (last_nibble) begin
        idx_q       <= '0;
        carry_out_q <= adder_cout;
        // Overflow occurs when the addends share a sign and the result sign
        // differs. Beff already holds the inverted B for subtract, so one
        // rule covers both operations.
        overflow_q  <= (a_q[NIBBLES-1][3] == beff_q[NIBBLES-1][3]) &&
                       (adder_sum[3] != a_q[NIBBLES-1][3]);
      end else begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Adder drive: only RUN presents operands. Otherwise the adder sees zeros,
  // so it stays quiet while idle.
  // ---------------------------------------------------------------------
  always_comb begin
    adder_a   = 4'h0;
    adder_b   = 4'h0;
    adder_cin = 1'b0;
    if (state_q == S_RUN) begin
      adder_a   = a_q[idx_q];
      adder_b   = beff_q[idx_q];
      adder_cin = carry_q;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule
